square_move_ctrl: RTL and testbench

Motion controller for the on-screen square in the VGA start screen. It conditions the four raw push-buttons by synchronizing and debouncing them, then schedules position updates once per video frame during vertical blanking, with a slow-then-fast acceleration profile. It drives the registered square position consumed by the square renderer, replacing per-pixel-clock movement with tear-free, human-rate motion.

---
 rtl/square_move_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_square_move_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_move_ctrl.sv
// square_move_ctrl: button-driven motion controller for the start-screen square.
// Buttons are synchronized and debounced. The position then moves once per frame,
// at the start of vertical blanking, with a slow-then-fast acceleration profile.
// Optional macro SQUARE_WRAP_EN makes the square wrap around the screen edges
// instead of stopping at them.
module square_move_ctrl #(
   parameter int HRES            = 640,
   parameter int VRES            = 480,
   parameter int SQUARE_SIZE     = 16,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int STEP_SLOW       = 1,
   parameter int STEP_FAST       = 4,
   parameter int HOLD_FRAMES     = 30
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic       frame_tick,
   output logic       moving
);

   localparam int MAX_X  = HRES - SQUARE_SIZE;
   localparam int MAX_Y  = VRES - SQUARE_SIZE;
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

   localparam logic signed [10:0] LIM_X = 11'(MAX_X);
   localparam logic signed [10:0] LIM_Y = 11'(MAX_Y);

   typedef enum logic [1:0] {
      IDLE,
      MOVE_SLOW,
      MOVE_FAST
   } state_t;

   // Bit order: 0 = left, 1 = right, 2 = up, 3 = down
   logic [3:0]      btn_raw;
   logic [3:0]      sync1;
   logic [3:0]      sync2;
   logic [3:0]      deb;
   logic [DB_W-1:0] db_cnt [4];

   state_t              state;
   state_t              state_nx;
   logic [HOLD_W-1:0]   hold;
   logic [HOLD_W-1:0]   hold_nx;
   logic signed [1:0]   dir_x;
   logic signed [1:0]   dir_y;
   logic signed [1:0]   dir_x_nx;
   logic signed [1:0]   dir_y_nx;
   logic signed [1:0]   dx;
   logic signed [1:0]   dy;
   logic                do_step;
   logic                step_fast;
   logic [9:0]          pos_x_nx;
   logic [9:0]          pos_y_nx;

   assign btn_raw = {btn_down, btn_up, btn_right, btn_left};

   // Adds one signed step to an axis and then clamps or wraps the result into 0..lim.
   function automatic logic [9:0] step_axis(input logic [9:0] p,
                                            input logic signed [1:0] d,
                                            input logic fast,
                                            input logic signed [10:0] lim);
      logic signed [10:0] mag;
      logic signed [10:0] delta;
      logic signed [10:0] sum;
      mag   = fast ? 11'(STEP_FAST) : 11'(STEP_SLOW);
      delta = '0;
      if (d > 2'sd0)
         delta = mag;
      else if (d < 2'sd0)
         delta = -mag;
      sum = $signed({1'b0, p}) + delta;
`ifdef SQUARE_WRAP_EN
      if (sum < 0)
         sum = sum + (lim + 11'sd1);
      else if (sum > lim)
         sum = sum - (lim + 11'sd1);
`else
      if (sum < 0)
         sum = '0;
      else if (sum > lim)
         sum = lim;
`endif
      return sum[9:0];
   endfunction

   // Two-flop synchronizer for the asynchronous button inputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Per-button debounce: accept a new level only after it has been stable for DEBOUNCE_CYCLES
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb <= '0;
         for (int unsigned i = 0; i < 4; i++)
            db_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               deb[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Frame tick at the first pixel of vertical blanking, suppressed while in reset
   always_comb begin
      frame_tick = reset_n && (x == 10'd0) && (y == 10'(VRES));
   end

   // Direction vector from the debounced levels; opposing buttons cancel each other
   always_comb begin
      dx = 2'sd0;
      dy = 2'sd0;
      if (deb[1] && !deb[0])
         dx = 2'sd1;
      else if (deb[0] && !deb[1])
         dx = -2'sd1;
      if (deb[3] && !deb[2])
         dy = 2'sd1;
      else if (deb[2] && !deb[3])
         dy = -2'sd1;
   end

   // Next-state, hold counter and step selection, evaluated only on frame_tick
   always_comb begin
      state_nx  = state;
      hold_nx   = hold;
      dir_x_nx  = dir_x;
      dir_y_nx  = dir_y;
      do_step   = 1'b0;
      step_fast = 1'b0;
      if (frame_tick) begin
         unique case (state)
            IDLE: begin
               if (dx != 2'sd0 || dy != 2'sd0) begin
                  do_step  = 1'b1;
                  hold_nx  = HOLD_W'(1);
                  dir_x_nx = dx;
                  dir_y_nx = dy;
                  state_nx = MOVE_SLOW;
               end
            end
            MOVE_SLOW: begin
               if (dx == 2'sd0 && dy == 2'sd0) begin
                  hold_nx  = '0;
                  state_nx = IDLE;
               end else if (dx != dir_x || dy != dir_y) begin
                  do_step  = 1'b1;
                  hold_nx  = HOLD_W'(1);
                  dir_x_nx = dx;
                  dir_y_nx = dy;
               end else begin
                  do_step = 1'b1;
                  if (hold != HOLD_W'(HOLD_FRAMES))
                     hold_nx = hold + HOLD_W'(1);
                  if (hold_nx == HOLD_W'(HOLD_FRAMES))
                     state_nx = MOVE_FAST;
               end
            end
            MOVE_FAST: begin
               if (dx == 2'sd0 && dy == 2'sd0) begin
                  hold_nx  = '0;
                  state_nx = IDLE;
               end else if (dx != dir_x || dy != dir_y) begin
                  do_step  = 1'b1;
                  hold_nx  = HOLD_W'(1);
                  dir_x_nx = dx;
                  dir_y_nx = dy;
                  state_nx = MOVE_SLOW;
               end else begin
                  do_step   = 1'b1;
                  step_fast = 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Candidate position for this frame; each axis is limited independently
   always_comb begin
      pos_x_nx = pos_x;
      pos_y_nx = pos_y;
      if (do_step) begin
         pos_x_nx = step_axis(pos_x, dx, step_fast, LIM_X);
         pos_y_nx = step_axis(pos_y, dy, step_fast, LIM_Y);
      end
   end

   // Motion state and position registers; they change only on frame_tick edges
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         hold  <= '0;
         dir_x <= 2'sd0;
         dir_y <= 2'sd0;
         pos_x <= 10'(MAX_X / 2);
         pos_y <= 10'(MAX_Y / 2);
      end else begin
         state <= state_nx;
         hold  <= hold_nx;
         dir_x <= dir_x_nx;
         dir_y <= dir_y_nx;
         pos_x <= pos_x_nx;
         pos_y <= pos_y_nx;
      end
   end

   // Moving flag follows the registered state
   always_comb begin
      moving = (state != IDLE);
   end

endmodule

// File: tb/tb_square_move_ctrl.sv
// Testbench for square_move_ctrl: randomized and directed button stimulus checked
// against a frame-level reference model (a run-length based acceleration rule).
// x/y come from a compressed raster: 8 pixels by lines 476..484, so that a
// frame_tick occurs every 72 cycles. The DUT only acts on x==0, y==VRES.
module tb_square_move_ctrl;

   localparam int DB   = 4;
   localparam int HF   = 3;
   localparam int MAXX = 624;
   localparam int MAXY = 464;
   localparam int VRES = 480;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       bl, br, bu, bd;
   logic [9:0] x, y;
   logic [9:0] pos_x, pos_y;
   logic       frame_tick, moving;

   int vectors = 0;
   int errors  = 0;

   // reference model state
   int mx, my, run, pdx, pdy;

   square_move_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .HOLD_FRAMES(HF)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .btn_left(bl),
      .btn_right(br),
      .btn_up(bu),
      .btn_down(bd),
      .x(x),
      .y(y),
      .pos_x(pos_x),
      .pos_y(pos_y),
      .frame_tick(frame_tick),
      .moving(moving)
   );

   always #5 clk = ~clk;

   // compressed raster, advanced on the falling edge
   initial begin
      x = 10'd0;
      y = 10'd476;
      forever begin
         @(negedge clk);
         if (x == 10'd7) begin
            x = 10'd0;
            y = (y == 10'd484) ? 10'd476 : y + 10'd1;
         end else begin
            x = x + 10'd1;
         end
      end
   end

   function automatic int axis(input int p, input int d, input int lim);
      int v;
      v = p + d;
`ifdef SQUARE_WRAP_EN
      v = ((v % (lim + 1)) + lim + 1) % (lim + 1);
`else
      if (v < 0) v = 0;
      if (v > lim) v = lim;
`endif
      return v;
   endfunction

   task automatic model_reset();
      mx = 312; my = 232; run = 0; pdx = 0; pdy = 0;
   endtask

   // one frame: count consecutive frames of the same non-zero direction;
   // the first HF frames move slowly, later ones fast
   task automatic model_frame();
      int dx, dy, st;
      dx = int'(br) - int'(bl);
      dy = int'(bd) - int'(bu);
      if (dx == 0 && dy == 0) begin
         run = 0;
      end else begin
         if (run == 0 || dx != pdx || dy != pdy) run = 1;
         else run++;
         st = (run > HF) ? 4 : 1;
         mx = axis(mx, dx * st, MAXX);
         my = axis(my, dy * st, MAXY);
         pdx = dx; pdy = dy;
      end
   endtask

   // wait for the next tick edge (bounded), sample 1 ns later and advance the model
   task automatic advance(output bit ok, output logic tk);
      ok = 1'b0;
      tk = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (x == 10'd0 && y == 10'(VRES)) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      tk = frame_tick;
      if (ok) model_frame();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bl = 0; br = 0; bu = 0; bd = 0;
      model_reset();
      #23;
      vectors++;
      if (pos_x !== 10'd312 || pos_y !== 10'd232 || moving !== 1'b0 || frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset: pos=(%0d,%0d) mov=%b tick=%b, expected (312,232) 0 0",
                  pos_x, pos_y, moving, frame_tick);
      end
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (x == 10'd0 && y == 10'(VRES)) break;
      end
      #1 reset_n = 1'b1;
   endtask

   task automatic test_right_accel();
      int exp_x[5] = '{313, 314, 315, 319, 323};
      bit ok; logic tk;
      br = 1;
      for (int f = 0; f < 5; f++) begin
         advance(ok, tk);
         vectors++;
         if (!ok || tk !== 1'b1 || pos_x !== exp_x[f] || pos_y !== 10'd232 ||
             pos_x !== mx || moving !== 1'b1) begin
            errors++;
            $display("FAIL right_accel f%0d: ok=%b tick=%b pos=(%0d,%0d) mov=%b, expected (%0d,232) 1",
                     f, ok, tk, pos_x, pos_y, moving, exp_x[f]);
         end
      end
   endtask

   task automatic test_reset_mid_move();
      bit ok; logic tk;
      advance(ok, tk);
      repeat (20) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (pos_x !== 10'd312 || pos_y !== 10'd232 || moving !== 1'b0 || frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_move: pos=(%0d,%0d) mov=%b tick=%b, expected (312,232) 0 0",
                  pos_x, pos_y, moving, frame_tick);
      end
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (x == 10'd0 && y == 10'(VRES)) break;
      end
      #1 reset_n = 1'b1;
      advance(ok, tk);
      vectors++;
      if (!ok || pos_x !== 10'd313 || pos_y !== 10'd232 || moving !== 1'b1) begin
         errors++;
         $display("FAIL reset_restart: pos=(%0d,%0d) mov=%b, expected (313,232) 1",
                  pos_x, pos_y, moving);
      end
   endtask

   task automatic test_right_edge();
      bit ok; logic tk;
      br = 1; bl = 0; bu = 0; bd = 0;
      for (int f = 0; f < 90; f++) begin
         advance(ok, tk);
         vectors++;
         if (!ok || tk !== 1'b1 || pos_x !== mx || pos_y !== my || moving !== (run > 0)) begin
            errors++;
            $display("FAIL right_edge f%0d: pos=(%0d,%0d) mov=%b, expected (%0d,%0d) %b",
                     f, pos_x, pos_y, moving, mx, my, run > 0);
         end
      end
`ifndef SQUARE_WRAP_EN
      vectors++;
      if (pos_x !== 10'd624) begin
         errors++;
         $display("FAIL right_saturate: pos_x=%0d, expected 624", pos_x);
      end
`endif
   endtask

   task automatic test_cancel();
      bit ok; logic tk;
      int x0;
      x0 = mx;
      bl = 1; br = 1; bu = 0; bd = 1;
      for (int f = 0; f < 4; f++) begin
         advance(ok, tk);
         vectors++;
         if (!ok || pos_x !== x0 || pos_y !== my || moving !== 1'b1) begin
            errors++;
            $display("FAIL cancel f%0d: pos=(%0d,%0d) mov=%b, expected (%0d,%0d) 1",
                     f, pos_x, pos_y, moving, x0, my);
         end
      end
   endtask

   task automatic test_glitch();
      bit ok; logic tk;
      int y0;
      bl = 0; br = 0; bu = 0; bd = 0;
      advance(ok, tk);
      y0 = my;
      repeat (64) @(negedge clk);
      vectors++;
      if (frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL tick_idle: frame_tick=%b, expected 0", frame_tick);
      end
      bu = 1;
      repeat (3) @(negedge clk);
      bu = 0;
      for (int f = 0; f < 2; f++) begin
         advance(ok, tk);
         vectors++;
         if (!ok || pos_y !== y0 || pos_x !== mx || moving !== 1'b0) begin
            errors++;
            $display("FAIL glitch f%0d: pos=(%0d,%0d) mov=%b, expected (%0d,%0d) 0",
                     f, pos_x, pos_y, moving, mx, y0);
         end
      end
   endtask

   task automatic test_dir_change();
      bit ok; logic tk;
      int yexp;
      br = 1;
      for (int f = 0; f < 5; f++) advance(ok, tk);
      br = 0; bu = 1;
      yexp = axis(my, -1, MAXY);
      for (int f = 0; f < 3; f++) begin
         advance(ok, tk);
         vectors++;
         if (!ok || pos_x !== mx || pos_y !== my || (f == 0 && pos_y !== yexp) || moving !== 1'b1) begin
            errors++;
            $display("FAIL dir_change f%0d: pos=(%0d,%0d) mov=%b, expected (%0d,%0d) 1",
                     f, pos_x, pos_y, moving, mx, my);
         end
      end
   endtask

   task automatic test_left_edge();
      bit ok; logic tk;
      bl = 1; br = 0; bu = 1; bd = 0;
      for (int f = 0; f < 170; f++) begin
         advance(ok, tk);
         vectors++;
         if (!ok || pos_x !== mx || pos_y !== my || moving !== 1'b1) begin
            errors++;
            $display("FAIL left_edge f%0d: pos=(%0d,%0d) mov=%b, expected (%0d,%0d) 1",
                     f, pos_x, pos_y, moving, mx, my);
         end
      end
`ifndef SQUARE_WRAP_EN
      vectors++;
      if (pos_x !== 10'd0 || pos_y !== 10'd0) begin
         errors++;
         $display("FAIL left_saturate: pos=(%0d,%0d), expected (0,0)", pos_x, pos_y);
      end
`endif
   endtask

   task automatic test_random();
      bit ok; logic tk;
      logic [3:0] b;
      for (int s = 0; s < 60; s++) begin
         b = 4'($urandom_range(0, 15));
         {bd, bu, br, bl} = b;
         for (int f = 0; f < int'($urandom_range(1, 5)); f++) begin
            advance(ok, tk);
            vectors++;
            if (!ok || tk !== 1'b1 || pos_x !== mx || pos_y !== my || moving !== (run > 0)) begin
               errors++;
               $display("FAIL random s%0d btn=%b: pos=(%0d,%0d) mov=%b, expected (%0d,%0d) %b",
                        s, b, pos_x, pos_y, moving, mx, my, run > 0);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_right_accel();
      test_reset_mid_move();
      test_right_edge();
      test_cancel();
      test_glitch();
      test_dir_change();
      test_left_edge();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
